seq_tx: RTL and testbench
=========================

Name: seq_tx

Overview:
- Serial pattern transmitter: on a start request it shifts out a stored bit pattern, MSB first, on a single line (`dout`).
- Each bit is held for a programmable number of clocks.
- The pattern can be repeated with idle gaps between copies.
- It is the source end of the serial-sequence link. It drives the `din` input of the team's Moore sequence detectors for on-board loopback and self-test, and it exposes its present state for LED display.

Parameters:
- W, 8: pattern register width in bits.
- LW, 4: width of the `len` port; must satisfy 2^LW > W.
- BIT_DIV, 4: clocks each bit is held on `dout`; must be >= 1.
- GAP_BITS, 1: bit-times of `dout`=0 inserted between repetitions; must be >= 1.

Ports:
- fsm_clk  in  1  system clock; all state changes on the rising edge.
- clr_n  in  1  reset, asynchronous, active-low.
- start  in  1  transmit request; sampled only in IDLE.
- pattern  in  W  bits to send, right-aligned; bit len-1 is sent first.
- len  in  LW  number of bits to send, 1..W; 0 or any value > W is treated as W.
- reps  in  4  number of transmissions; 0 is treated as 1.
- dout  out  1  serial output.
- busy  out  1  high while in SEND or GAP.
- done  out  1  one-cycle pulse when the whole job finishes.
- ps  out  3  present state, for LEDs.

Behaviour:
- Reset: clr_n low forces, immediately and asynchronously, ps=IDLE, dout=0, busy=0, done=0, and clears all counters and the shift register. This applies mid-transmission too; the job is abandoned and no done pulse occurs.
- State encoding:
  - IDLE=000, SEND=001, GAP=010, DONE=011.
  - Unused codes go to IDLE on the next edge.
- IDLE:
  - dout=0.
  - On an edge with start=1: latch pattern, effective len and effective reps into internal registers.
  - Load shift register = latched pattern << (W-len), i.e. left-aligned; set bit counter=len, divider=0, rep counter=reps; go to SEND.
- SEND (Moore output):
  - dout = shift register MSB.
  - Divider counts 0..BIT_DIV-1.
  - At divider=BIT_DIV-1: shift left by one and decrement the bit counter.
  - When the final bit's hold completes:
    - if rep counter > 1: decrement rep counter, go to GAP;
    - else go to DONE.
- Timing:
  - The first bit is on dout during the cycle immediately after the start edge.
  - Each transmission occupies exactly len*BIT_DIV cycles.
- GAP:
  - dout=0 for exactly GAP_BITS*BIT_DIV cycles.
  - Then reload the shift register from the latched pattern (left-aligned), set bit counter=len, and return to SEND.
  - No extra bubble cycle between GAP and SEND.
- DONE:
  - Lasts one cycle: done=1, dout=0, busy=0.
  - Then go to IDLE.
  - start is ignored in DONE; the earliest new job is accepted the cycle after, in IDLE.
- start in SEND, GAP or DONE is ignored.
- Changes on pattern, len or reps after the latching edge have no effect on the job in progress.
- All outputs are decoded from registered state and counters: glitch-free, no combinational path from inputs to outputs.
- Total job length from start edge to done high: reps_eff*len_eff*BIT_DIV + (reps_eff-1)*GAP_BITS*BIT_DIV cycles, with done high in the cycle after that.

Test Plan:
1. W=8, BIT_DIV=4, pattern=8'h0A, len=4, reps=0, start pulse -> dout=1,0,1,0, each bit for 4 cycles starting 1 cycle after the start edge; busy high 16 cycles; done high exactly 1 cycle, 17 cycles after the start edge; dout=0 afterwards.
2. Same setup, reps=3, GAP_BITS=1 -> dout sequence 1010 0 1010 0 1010 (bit-times of 4 cycles); busy continuous for 56 cycles; exactly one done pulse.
3. len=0, pattern=8'hA5 -> 8 bits 1,0,1,0,0,1,0,1 sent; len=9 gives the same result.
4. Mid-job: start re-pulsed and pattern changed to 8'hFF during SEND -> no restart; output continues from the latched pattern; single done.
5. clr_n driven low asynchronously (between edges) during the second bit -> ps=000, dout=0, busy=0 without waiting for a clock; no done; a new start after release transmits normally.
6. Loopback: BIT_DIV=1, pattern=4'b1010, len=4, dout wired to the detector's din on the same fsm_clk -> detector seq_det pulses exactly once per transmission; with reps=2 it pulses twice.

Source files
------------

// File: rtl/seq_tx.sv
// -----------------------------------------------------------------------------
// seq_tx : serial pattern transmitter
//
// On a start request in IDLE the block latches a bit pattern, an effective
// length and an effective repeat count. It then shifts the pattern out MSB
// first on dout, holding each bit for BIT_DIV clocks. Between copies it drives
// GAP_BITS bit-times of zero. When the job completes it pulses done for one
// cycle and returns to IDLE.
//
// Ports
//   fsm_clk  in   1   system clock, rising edge
//   clr_n    in   1   asynchronous active-low reset
//   start    in   1   transmit request, sampled only in IDLE
//   pattern  in   W   bits to send, right-aligned (bit len-1 goes first)
//   len      in   LW  bits to send, 1..W (0 or >W means W)
//   reps     in   4   number of copies (0 means 1)
//   dout     out  1   serial output
//   busy     out  1   high in SEND or GAP
//   done     out  1   one-cycle pulse at end of job
//   ps       out  3   present state (IDLE=000 SEND=001 GAP=010 DONE=011)
//
// Every output is decoded from registered state, so there is no combinational
// path from an input to an output.
// -----------------------------------------------------------------------------
module seq_tx #(
   parameter int W        = 8,
   parameter int LW       = 4,
   parameter int BIT_DIV  = 4,
   parameter int GAP_BITS = 1
) (
   input  logic          fsm_clk,
   input  logic          clr_n,
   input  logic          start,
   input  logic [W-1:0]  pattern,
   input  logic [LW-1:0] len,
   input  logic [3:0]    reps,
   output logic          dout,
   output logic          busy,
   output logic          done,
   output logic [2:0]    ps
);

   localparam logic [2:0] S_IDLE = 3'b000;
   localparam logic [2:0] S_SEND = 3'b001;
   localparam logic [2:0] S_GAP  = 3'b010;
   localparam logic [2:0] S_DONE = 3'b011;

   localparam int GAP_CYC = GAP_BITS * BIT_DIV;
   localparam int DW      = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;
   localparam int GW      = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

   localparam logic [DW-1:0] DIV_MAX = DW'(BIT_DIV - 1);
   localparam logic [GW-1:0] GAP_MAX = GW'(GAP_CYC - 1);
   localparam logic [LW-1:0] W_LEN   = LW'(W);

   // state and datapath registers
   logic [2:0]    state_reg;
   logic [2:0]    state_next;
   logic [W-1:0]  pat_reg;
   logic [LW-1:0] len_reg;
   logic [3:0]    rep_reg;
   logic [W-1:0]  shift_reg;
   logic [LW-1:0] bit_cnt_reg;
   logic [DW-1:0] div_reg;
   logic [GW-1:0] gap_reg;

   // effective job parameters as seen on the start edge
   logic [LW-1:0] len_eff;
   logic [3:0]    reps_eff;
   logic [W-1:0]  load_shift;
   logic [W-1:0]  reload_shift;

   // datapath event flags
   logic bit_end;
   logic last_bit;
   logic more_reps;
   logic gap_end;

   assign len_eff  = ((len == '0) || (len > W_LEN)) ? W_LEN : len;
   assign reps_eff = (reps == 4'd0) ? 4'd1 : reps;

   // Left-align so that bit len-1 of the pattern lands in the MSB; the
   // shift register then only ever needs to look at its top bit.
   assign load_shift   = pattern << (W_LEN - len_eff);
   assign reload_shift = pat_reg << (W_LEN - len_reg);

   assign bit_end   = (div_reg == DIV_MAX);
   assign last_bit  = (bit_cnt_reg == LW'(1));
   assign more_reps = (rep_reg > 4'd1);
   assign gap_end   = (gap_reg == GAP_MAX);

   // ------------------------------------------------------------------
   // state register
   // ------------------------------------------------------------------
   always_ff @(posedge fsm_clk or negedge clr_n) begin
      if (!clr_n) begin
         state_reg <= S_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // ------------------------------------------------------------------
   // next-state logic
   // ------------------------------------------------------------------
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         S_IDLE: begin
            if (start) begin
               state_next = S_SEND;
            end
         end
         S_SEND: begin
            if (bit_end && last_bit) begin
               state_next = more_reps ? S_GAP : S_DONE;
            end
         end
         S_GAP: begin
            // straight back into SEND, no bubble cycle
            if (gap_end) begin
               state_next = S_SEND;
            end
         end
         S_DONE: begin
            // start is deliberately not looked at here
            state_next = S_IDLE;
         end
         default: begin
            state_next = S_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // output decode (Moore)
   // ------------------------------------------------------------------
   always_comb begin
      dout = 1'b0;
      busy = 1'b0;
      done = 1'b0;
      case (state_reg)
         S_SEND: begin
            dout = shift_reg[W-1];
            busy = 1'b1;
         end
         S_GAP: begin
            busy = 1'b1;
         end
         S_DONE: begin
            done = 1'b1;
         end
         default: begin
            dout = 1'b0;
         end
      endcase
   end

   assign ps = state_reg;

   // ------------------------------------------------------------------
   // datapath: latched job, shift register and counters
   // ------------------------------------------------------------------
   always_ff @(posedge fsm_clk or negedge clr_n) begin
      if (!clr_n) begin
         pat_reg     <= '0;
         len_reg     <= '0;
         rep_reg     <= '0;
         shift_reg   <= '0;
         bit_cnt_reg <= '0;
         div_reg     <= '0;
         gap_reg     <= '0;
      end else begin
         case (state_reg)
            S_IDLE: begin
               if (start) begin
                  pat_reg     <= pattern;
                  len_reg     <= len_eff;
                  rep_reg     <= reps_eff;
                  shift_reg   <= load_shift;
                  bit_cnt_reg <= len_eff;
                  div_reg     <= '0;
                  gap_reg     <= '0;
               end
            end
            S_SEND: begin
               if (bit_end) begin
                  div_reg     <= '0;
                  shift_reg   <= shift_reg << 1;
                  bit_cnt_reg <= bit_cnt_reg - LW'(1);
                  if (last_bit && more_reps) begin
                     rep_reg <= rep_reg - 4'd1;
                     gap_reg <= '0;
                  end
               end else begin
                  div_reg <= div_reg + DW'(1);
               end
            end
            S_GAP: begin
               if (gap_end) begin
                  // next copy comes from the latched pattern, not the port
                  shift_reg   <= reload_shift;
                  bit_cnt_reg <= len_reg;
                  div_reg     <= '0;
                  gap_reg     <= '0;
               end else begin
                  gap_reg <= gap_reg + GW'(1);
               end
            end
            default: begin
               div_reg <= '0;
               gap_reg <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_seq_tx.sv
// -----------------------------------------------------------------------------
// tb_seq_tx : directed testbench for seq_tx
//
// Main instance uses W=8, BIT_DIV=4, GAP_BITS=1. A second instance with
// BIT_DIV=1 feeds a small 1010 detector model for the loopback scenario.
// Inputs change 1 ns after the rising edge; outputs are sampled there too.
// -----------------------------------------------------------------------------
module tb_seq_tx;

   localparam int W   = 8;
   localparam int LW  = 4;
   localparam int DIV = 4;

   logic          fsm_clk = 1'b0;
   logic          clr_n;
   logic          start;
   logic [W-1:0]  pattern;
   logic [LW-1:0] len;
   logic [3:0]    reps;
   logic          dout;
   logic          busy;
   logic          done;
   logic [2:0]    ps;

   // loopback instance
   logic          f_start;
   logic [W-1:0]  f_pattern;
   logic [LW-1:0] f_len;
   logic [3:0]    f_reps;
   logic          f_dout;
   logic          f_busy;
   logic          f_done;
   logic [2:0]    f_ps;

   int n_cmp = 0;
   int n_err = 0;
   int done_cnt = 0;
   int hits = 0;
   logic [3:0] hist = 4'b0000;

   always #5 fsm_clk = ~fsm_clk;

   seq_tx #(.W(W), .LW(LW), .BIT_DIV(DIV), .GAP_BITS(1)) u_dut (
      .fsm_clk (fsm_clk),
      .clr_n   (clr_n),
      .start   (start),
      .pattern (pattern),
      .len     (len),
      .reps    (reps),
      .dout    (dout),
      .busy    (busy),
      .done    (done),
      .ps      (ps)
   );

   seq_tx #(.W(W), .LW(LW), .BIT_DIV(1), .GAP_BITS(1)) u_fast (
      .fsm_clk (fsm_clk),
      .clr_n   (clr_n),
      .start   (f_start),
      .pattern (f_pattern),
      .len     (f_len),
      .reps    (f_reps),
      .dout    (f_dout),
      .busy    (f_busy),
      .done    (f_done),
      .ps      (f_ps)
   );

   always @(posedge fsm_clk) begin
      if (done) done_cnt <= done_cnt + 1;
   end

   // overlapping 1010 detector on the fast instance output
   always @(posedge fsm_clk) begin
      hist <= {hist[2:0], f_dout};
      if ({hist[2:0], f_dout} == 4'b1010) hits <= hits + 1;
   end

   task automatic tick();
      @(posedge fsm_clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Start a job and check dout bit-time by bit-time against seq (MSB first),
   // then the done cycle. inj>=0 pulses start with pattern=FF at that cycle.
   // sid=1 holds start high during the DONE cycle to show it is ignored.
   task automatic run(input string tag, input logic [W-1:0] pat, input logic [LW-1:0] ln,
                      input logic [3:0] rp, input logic [63:0] seq, input int nbits,
                      input int inj, input bit sid);
      int d0;
      pattern = pat; len = ln; reps = rp; start = 1'b1;
      tick();
      start = 1'b0;
      d0 = done_cnt;
      for (int b = 0; b < nbits; b++) begin
         for (int c = 0; c < DIV; c++) begin
            if (b * DIV + c == inj) begin
               start = 1'b1; pattern = 8'hFF;
            end else begin
               start = 1'b0;
            end
            chk({tag, " dout"}, 32'(dout), 32'(seq[nbits-1-b]));
            chk({tag, " busy"}, 32'(busy), 32'd1);
            chk({tag, " done_low"}, 32'(done), 32'd0);
            tick();
         end
      end
      start = 1'b0;
      chk({tag, " done_pulse"}, 32'(done), 32'd1);
      chk({tag, " done_busy"}, 32'(busy), 32'd0);
      chk({tag, " done_dout"}, 32'(dout), 32'd0);
      chk({tag, " done_ps"}, 32'(ps), 32'd3);
      if (sid) start = 1'b1;
      tick();
      start = 1'b0;
      chk({tag, " idle_ps"}, 32'(ps), 32'd0);
      chk({tag, " idle_done"}, 32'(done), 32'd0);
      chk({tag, " idle_dout"}, 32'(dout), 32'd0);
      chk({tag, " done_count"}, 32'(done_cnt), 32'(d0 + 1));
      tick();
      chk({tag, " still_idle"}, 32'(ps), 32'd0);
      $display("job %s checked, %0d compared so far", tag, n_cmp);
   endtask

   initial begin
      int d0;
      clr_n = 1'b0; start = 1'b0; pattern = '0; len = '0; reps = '0;
      f_start = 1'b0; f_pattern = '0; f_len = '0; f_reps = '0;
      #1;
      chk("reset ps", 32'(ps), 32'd0);
      chk("reset dout", 32'(dout), 32'd0);
      chk("reset busy", 32'(busy), 32'd0);
      chk("reset done", 32'(done), 32'd0);
      tick(); tick();
      #2 clr_n = 1'b1;
      tick();
      chk("idle ps", 32'(ps), 32'd0);

      // 1: 0x0A, len 4, reps 0 -> 1010 once
      run("t1", 8'h0A, 4'd4, 4'd0, 64'b1010, 4, -1, 1'b0);
      // 2: reps 3 -> 1010 0 1010 0 1010, busy continuous 56 cycles
      run("t2", 8'h0A, 4'd4, 4'd3, 64'b1010_0_1010_0_1010, 14, -1, 1'b0);
      // 3: len 0 and len 9 both send all 8 bits of 0xA5
      run("t3a", 8'hA5, 4'd0, 4'd1, 64'b1010_0101, 8, -1, 1'b0);
      run("t3b", 8'hA5, 4'd9, 4'd1, 64'b1010_0101, 8, -1, 1'b0);
      // 4: start re-pulsed with pattern FF mid-job; start held in DONE
      run("t4", 8'h0A, 4'd4, 4'd1, 64'b1010, 4, 6, 1'b1);

      // 5: asynchronous reset during the second bit
      pattern = 8'h0A; len = 4'd4; reps = 4'd1; start = 1'b1;
      tick();
      start = 1'b0;
      d0 = done_cnt;
      for (int i = 0; i < 5; i++) tick();
      chk("t5 pre busy", 32'(busy), 32'd1);
      chk("t5 pre dout", 32'(dout), 32'd0);
      #3 clr_n = 1'b0;
      #1;
      chk("t5 async ps", 32'(ps), 32'd0);
      chk("t5 async busy", 32'(busy), 32'd0);
      chk("t5 async dout", 32'(dout), 32'd0);
      tick(); tick();
      #2 clr_n = 1'b1;
      for (int i = 0; i < 20; i++) tick();
      chk("t5 no_done", 32'(done_cnt), 32'(d0));
      chk("t5 idle", 32'(ps), 32'd0);
      run("t5b", 8'h0A, 4'd4, 4'd1, 64'b1010, 4, -1, 1'b0);

      // 6: loopback, BIT_DIV=1, 1010 detector
      d0 = hits;
      f_pattern = 8'h0A; f_len = 4'd4; f_reps = 4'd1; f_start = 1'b1;
      tick();
      f_start = 1'b0;
      for (int i = 0; i < 10; i++) tick();
      chk("t6 one_hit", 32'(hits), 32'(d0 + 1));
      chk("t6 idle", 32'(f_ps), 32'd0);
      f_reps = 4'd2; f_start = 1'b1;
      tick();
      f_start = 1'b0;
      for (int i = 0; i < 15; i++) tick();
      chk("t6 two_hits", 32'(hits), 32'(d0 + 3));
      chk("t6 idle2", 32'(f_ps), 32'd0);
      $display("loopback checked, %0d compared so far", n_cmp);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
